result_tx_serializer: RTL and testbench

//  Downstream of the 3x3 Calculator: captures its 144-bit result bus (9 x 16-bit, row-major)
//  and streams the active size x size sub-matrix as bytes to uart_tx via start/busy.

---
 rtl/result_tx_serializer_pkg.sv | 26 ++
 rtl/result_tx_serializer_index_gen.sv | 61 ++++++
 rtl/result_tx_serializer.sv | 219 +++++++++++++++++++++
 tb/tb_result_tx_serializer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_tx_serializer_pkg.sv
// Shared types and helpers for the result byte serializer.
// Optional feature macro: RESULT_TX_CHECKSUM_EN (adds the TAIL checksum byte).
package result_tx_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
`ifdef RESULT_TX_CHECKSUM_EN
    ST_TAIL    = 3'd4,
`endif
    ST_FINISH  = 3'd5
  } tx_state_e;

  // Counter width able to index 0..count-1 (at least one bit).
  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // Requested dimension limited to the largest matrix the bus carries.
  function automatic logic [3:0] clamp_dim(input logic [3:0] n, input logic [3:0] max_dim);
    return (n > max_dim) ? max_dim : n;
  endfunction

endpackage

// File: rtl/result_tx_serializer_index_gen.sv
// result_index_gen: walks row, column and byte of the active n x n sub-matrix.
// Produces the flat bus element index (r*MAX_DIM+c), the byte select (0 = MS byte)
// and a flag marking the final byte of the frame.
module result_index_gen
  import result_tx_serializer_pkg::*;
#(
  parameter int MAX_DIM = 3,
  parameter int BYTES   = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    clr,
  input  logic                                    adv,
  input  logic [3:0]                              n,
  output logic [idx_width(MAX_DIM*MAX_DIM)-1:0]   bus_idx,
  output logic [idx_width(BYTES)-1:0]             byte_sel,
  output logic                                    last
);

  localparam int IDX_W  = idx_width(MAX_DIM*MAX_DIM);
  localparam int BSEL_W = idx_width(BYTES);
  localparam logic [BSEL_W-1:0] BYTE_LAST = BSEL_W'(BYTES-1);

  logic [3:0]        row_reg;
  logic [3:0]        col_reg;
  logic [BSEL_W-1:0] byte_reg;
  logic              byte_wrap;
  logic              col_wrap;

  assign byte_wrap = (byte_reg == BYTE_LAST);
  assign col_wrap  = (col_reg == n - 4'd1);
  assign last      = byte_wrap && col_wrap && (row_reg == n - 4'd1);
  assign bus_idx   = IDX_W'(32'(row_reg) * 32'(MAX_DIM) + 32'(col_reg));
  assign byte_sel  = byte_reg;

  // Step byte, then column, then row; rows advance by MAX_DIM on the bus, not by n.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_reg  <= '0;
      col_reg  <= '0;
      byte_reg <= '0;
    end else if (clr) begin
      row_reg  <= '0;
      col_reg  <= '0;
      byte_reg <= '0;
    end else if (adv) begin
      if (byte_wrap) begin
        byte_reg <= '0;
        if (col_wrap) begin
          col_reg <= '0;
          row_reg <= row_reg + 4'd1;
        end else begin
          col_reg <= col_reg + 4'd1;
        end
      end else begin
        byte_reg <= byte_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_tx_serializer.sv
// result_tx_serializer: captures the calculator result bus and streams the active
// n x n sub-matrix to uart_tx as bytes (row-major, MS byte first) via tx_start/tx_busy.
// Optional feature macro: RESULT_TX_CHECKSUM_EN appends a modulo-256 sum byte.
module result_tx_serializer
  import result_tx_serializer_pkg::*;
#(
  parameter int ELEM_W       = 16,
  parameter int MAX_DIM      = 3,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] result,
  input  logic [3:0]                        matrix_size,
  input  logic                              tx_busy,
  output logic                              tx_start,
  output logic [7:0]                        tx_data,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int BYTES  = ELEM_W / 8;
  localparam int NELEM  = MAX_DIM * MAX_DIM;
  localparam int IDX_W  = idx_width(NELEM);
  localparam int BSEL_W = idx_width(BYTES);
  localparam int TO_W   = $clog2(BUSY_TIMEOUT + 1);

  tx_state_e                 state_reg, state_next;
  logic [NELEM*ELEM_W-1:0]   result_reg;
  logic [3:0]                n_reg;
  logic [TO_W-1:0]           to_cnt_reg;
  logic                      err_reg;
  logic [7:0]                tx_data_reg;
`ifdef RESULT_TX_CHECKSUM_EN
  logic [7:0]                sum_reg;
  logic                      tail_reg;
`endif

  logic                      accept;
  logic                      idx_clr;
  logic                      idx_adv;
  logic                      idx_last;
  logic                      byte_done;
  logic                      timeout_hit;
  logic [3:0]                load_n;
  logic [IDX_W-1:0]          bus_idx;
  logic [BSEL_W-1:0]         byte_sel;
  logic [ELEM_W-1:0]         elem [NELEM];
  logic [ELEM_W-1:0]         cur_elem;
  logic [7:0]                cur_byte;

  assign load_n = clamp_dim(matrix_size, 4'(MAX_DIM));
  assign err    = err_reg;

  result_index_gen #(
    .MAX_DIM (MAX_DIM),
    .BYTES   (BYTES)
  ) u_index_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (idx_clr),
    .adv      (idx_adv),
    .n        (n_reg),
    .bus_idx  (bus_idx),
    .byte_sel (byte_sel),
    .last     (idx_last)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NELEM; gi++) begin : g_elem
      assign elem[gi] = result_reg[gi*ELEM_W +: ELEM_W];
    end
  endgenerate

  // Pick the current element and its byte; byte_sel 0 is the most significant byte.
  always_comb begin
    cur_elem = '0;
    for (int e = 0; e < NELEM; e++) begin
      if (bus_idx == IDX_W'(e)) cur_elem = elem[e];
    end
    cur_byte = 8'h00;
    for (int b = 0; b < BYTES; b++) begin
      if (byte_sel == BSEL_W'(b)) cur_byte = cur_elem[(BYTES-1-b)*8 +: 8];
    end
  end

  // Next-state and decoded outputs; a byte is finished either by tx_busy falling or by timeout.
  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    idx_clr     = 1'b0;
    idx_adv     = 1'b0;
    byte_done   = 1'b0;
    timeout_hit = 1'b0;
    tx_start    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    tx_data     = tx_data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (load) begin
          accept     = 1'b1;
          idx_clr    = 1'b1;
          state_next = (load_n == 4'd0) ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        busy       = 1'b1;
        tx_start   = 1'b1;
        tx_data    = cur_byte;
        state_next = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        busy = 1'b1;
        if (tx_busy) begin
          state_next = ST_WAIT_LO;
        end else if (to_cnt_reg == TO_W'(BUSY_TIMEOUT-1)) begin
          timeout_hit = 1'b1;
          byte_done   = 1'b1;
        end
      end
      ST_WAIT_LO: begin
        busy = 1'b1;
        if (!tx_busy) byte_done = 1'b1;
      end
`ifdef RESULT_TX_CHECKSUM_EN
      ST_TAIL: begin
        busy       = 1'b1;
        tx_start   = 1'b1;
        tx_data    = sum_reg;
        state_next = ST_WAIT_HI;
      end
`endif
      ST_FINISH: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (byte_done) begin
`ifdef RESULT_TX_CHECKSUM_EN
      if (tail_reg) begin
        state_next = ST_FINISH;
      end else if (idx_last) begin
        state_next = ST_TAIL;
      end else begin
        idx_adv    = 1'b1;
        state_next = ST_ISSUE;
      end
`else
      if (idx_last) begin
        state_next = ST_FINISH;
      end else begin
        idx_adv    = 1'b1;
        state_next = ST_ISSUE;
      end
`endif
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Frame capture; only an accepted load from IDLE may overwrite the held data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_reg <= '0;
      n_reg      <= '0;
    end else if (accept) begin
      result_reg <= result;
      n_reg      <= load_n;
    end
  end

  // Counts WAIT_HI cycles spent without tx_busy; restarts for every byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      to_cnt_reg <= '0;
    else if (state_reg == ST_WAIT_HI && !tx_busy && !timeout_hit)
      to_cnt_reg <= to_cnt_reg + 1'b1;
    else
      to_cnt_reg <= '0;
  end

  // Sticky error and held byte; tx_data keeps the issued byte until the next request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg     <= 1'b0;
      tx_data_reg <= 8'h00;
    end else begin
      if (accept)           err_reg <= 1'b0;
      else if (timeout_hit) err_reg <= 1'b1;
      if (tx_start)         tx_data_reg <= tx_data;
    end
  end

`ifdef RESULT_TX_CHECKSUM_EN
  // Running sum of every issued data byte, including ones later skipped by timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_reg  <= 8'h00;
      tail_reg <= 1'b0;
    end else if (accept) begin
      sum_reg  <= 8'h00;
      tail_reg <= 1'b0;
    end else begin
      if (state_reg == ST_ISSUE) sum_reg  <= sum_reg + cur_byte;
      if (state_reg == ST_TAIL)  tail_reg <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_result_tx_serializer.sv
// Self-checking bench for result_tx_serializer: directed and randomized frames
// against a byte-list reference model, with a uart_tx model of adjustable busy time.
module tb_result_tx_serializer;

  localparam int ELEM_W       = 16;
  localparam int MAX_DIM      = 3;
  localparam int BUSY_TIMEOUT = 64;
  localparam int BYTES        = ELEM_W / 8;
  localparam int RES_W        = MAX_DIM * MAX_DIM * ELEM_W;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [RES_W-1:0] result;
  logic [3:0]       matrix_size;
  logic             tx_busy;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             busy;
  logic             done;
  logic             err;

  result_tx_serializer #(
    .ELEM_W       (ELEM_W),
    .MAX_DIM      (MAX_DIM),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .result      (result),
    .matrix_size (matrix_size),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         frame_cycles = 0;
  int         hold_cycles = 3;
  bit         uart_dead = 1'b0;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] save_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: list of bytes the frame must carry, straight from the byte-order rules.
  task automatic build_expected(input logic [RES_W-1:0] res, input int ms);
    int n;
    logic [ELEM_W-1:0] e;
    logic [7:0] sum;
    n   = (ms > MAX_DIM) ? MAX_DIM : ms;
    sum = 8'h00;
    exp_q.delete();
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        e = res[(r*MAX_DIM+c)*ELEM_W +: ELEM_W];
        for (int b = BYTES-1; b >= 0; b--) begin
          exp_q.push_back(e[b*8 +: 8]);
          sum = sum + e[b*8 +: 8];
        end
      end
    if (CSUM != 0 && n > 0) exp_q.push_back(sum);
  endtask

  task automatic compare_stream(input string tag);
    int m;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  // uart_tx model: raises tx_busy after a request and holds it hold_cycles cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && !uart_dead) begin
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (hold_cycles) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Monitor: collects issued bytes, counts done pulses, checks tx_data holds while busy.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (tx_start === 1'b1) begin
        got_q.push_back(tx_data);
        last_byte = tx_data;
      end else if (tx_busy && busy === 1'b1) begin
        chk("tx_data_stable", tx_data, last_byte);
      end
    end
  end

  task automatic run_frame(input logic [RES_W-1:0] res, input int ms, input string tag,
                           input int hold, input bit dead, input logic exp_err);
    int d0, c1, i, n, budget;
    n = (ms > MAX_DIM) ? MAX_DIM : ms;
    hold_cycles = hold;
    uart_dead   = dead;
    build_expected(res, ms);
    budget = (exp_q.size() + 1) * (hold + BUSY_TIMEOUT + 8) + 20;
    got_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    result      = res;
    matrix_size = ms[3:0];
    load        = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    #1;
    c1 = cyc;
    if (n > 0) begin
      chk({tag, "_start_latency"}, tx_start, 1'b1);
      chk({tag, "_busy_after_load"}, busy, 1'b1);
    end else begin
      chk({tag, "_n0_done"}, done, 1'b1);
      chk({tag, "_n0_no_start"}, tx_start, 1'b0);
    end
    chk({tag, "_err_cleared"}, err, 1'b0);
    i = 0;
    while (done_cnt == d0 && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk({tag, "_done_seen"}, (done_cnt != d0), 1'b1);
    frame_cycles = done_cyc - c1;
    compare_stream(tag);
    chk({tag, "_err"}, err, exp_err);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_busy_low"}, busy, 1'b0);
    $display("frame %s n=%0d bytes=%0d cycles=%0d err=%0b", tag, n, got_q.size(), frame_cycles, err);
  endtask

  logic [RES_W-1:0] res_a;
  logic [RES_W-1:0] res_b;

  initial begin
    int i, nb;
    rst         = 1'b0;
    load        = 1'b0;
    result      = '0;
    matrix_size = 4'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: n=2 directed values
    res_a = '0;
    res_a[0*ELEM_W +: ELEM_W] = 16'h1234;
    res_a[1*ELEM_W +: ELEM_W] = 16'h0056;
    res_a[3*ELEM_W +: ELEM_W] = 16'hABCD;
    res_a[4*ELEM_W +: ELEM_W] = 16'h0001;
    res_a[2*ELEM_W +: ELEM_W] = 16'hEEEE;
    res_a[5*ELEM_W +: ELEM_W] = 16'hEEEE;
    run_frame(res_a, 2, "t1_n2", 3, 1'b0, 1'b0);

    // Test 2: n=3, R(i)=0x0100+i
    for (int e = 0; e < 9; e++) res_a[e*ELEM_W +: ELEM_W] = 16'h0100 + 16'(e);
    run_frame(res_a, 3, "t2_n3", 2, 1'b0, 1'b0);

    // Test 3: same frame with short and long busy windows
    for (int e = 0; e < 9; e++) res_a[e*ELEM_W +: ELEM_W] = 16'($urandom);
    run_frame(res_a, 3, "t3_hold3", 3, 1'b0, 1'b0);
    save_q = got_q;
    run_frame(res_a, 3, "t3_hold200", 200, 1'b0, 1'b0);
    chk("t3_stream_equal", (save_q == got_q), 1'b1);

    // Test 4: tx_busy never rises -> timeout per byte, err set, next load clears it
    res_b = '0;
    res_b[0 +: ELEM_W] = 16'h5AA5;
    run_frame(res_b, 1, "t4_timeout", 3, 1'b1, 1'b1);
    nb = BYTES + CSUM;
    chk("t4_timeout_window", (frame_cycles >= nb*BUSY_TIMEOUT && frame_cycles <= nb*(BUSY_TIMEOUT+4)), 1'b1);
    run_frame(res_b, 1, "t4_recover", 3, 1'b0, 1'b0);

    // Test 5: load ignored mid-frame, then reset at byte 5
    for (int e = 0; e < 9; e++) res_a[e*ELEM_W +: ELEM_W] = 16'($urandom);
    for (int e = 0; e < 9; e++) res_b[e*ELEM_W +: ELEM_W] = ~res_a[e*ELEM_W +: ELEM_W];
    hold_cycles = 3;
    uart_dead   = 1'b0;
    build_expected(res_a, 3);
    got_q.delete();
    @(negedge clk);
    result = res_a; matrix_size = 4'd3; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    i = 0;
    while (got_q.size() < 2 && i < 200) begin @(negedge clk); #1; i++; end
    chk("t5_reach_byte2", (got_q.size() >= 2), 1'b1);
    result = res_b; matrix_size = 4'd1; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    i = 0;
    while (got_q.size() < 5 && i < 200) begin @(negedge clk); #1; i++; end
    chk("t5_reach_byte5", got_q.size(), 5);
    for (int k = 0; k < 5 && k < got_q.size(); k++)
      chk($sformatf("t5_prefix_byte%0d", k), got_q[k], exp_q[k]);
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_tx_start", tx_start, 1'b0);
    chk("t5_rst_tx_data", tx_data, 8'h00);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_done", done, 1'b0);
    chk("t5_rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_idle_after_rst", busy, 1'b0);
    $display("frame t5_abort n=3 bytes=%0d", got_q.size());
    run_frame(res_b, 3, "t5_restart", 3, 1'b0, 1'b0);

    // Test 6: n=0 and oversize n
    run_frame(res_a, 0, "t6_n0", 3, 1'b0, 1'b0);
    chk("t6_n0_latency", frame_cycles, 0);
    run_frame(res_a, 7, "t6_n7", 1, 1'b0, 1'b0);

    // Randomized frames
    for (int f = 0; f < 5; f++) begin
      for (int e = 0; e < 9; e++) res_a[e*ELEM_W +: ELEM_W] = 16'($urandom);
      run_frame(res_a, int'($urandom_range(1, MAX_DIM)), $sformatf("rand%0d", f),
                int'($urandom_range(1, 6)), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
